// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
package fetch_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 11;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam int          PC_STEP = 4;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr}; entry e0 is always the head, so no pointers are needed.
module fetch_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic [1:0]      count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t e0, e1, in_entry;

    assign in_entry = '{pc: push_pc, instr: push_instr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= in_entry;
                    else               e1 <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        e0 <= in_entry;
                    end else begin
                        e0 <= e1;
                        e1 <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_pc    = head_valid ? e0.pc    : '0;
    assign head_instr = head_valid ? e0.instr : '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, run/halt FSM, redirect handling, feeding a 2-entry buffer to decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic              halted
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [1:0]      count;
    logic            pop, fetch;

    assign imem_addr = pc[ADDR_W+1:2];
    assign pop       = out_valid & out_ready;
    assign fetch     = (state == RUN) & ~redirect_valid & ((count < 2'd2) | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            state  <= RUN;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc & ~XLEN'(3);
            state  <= RUN;
            halted <= 1'b0;
        end else if (fetch) begin
            pc <= pc + XLEN'(PC_STEP);
            // The ebreak itself is enqueued; fetching stops right after it.
            if (imem_data == XLEN'(EBREAK)) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
        end
    end

    fetch_buffer #(.XLEN(XLEN)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (fetch),
        .pop        (pop & ~redirect_valid),
        .flush      (redirect_valid),
        .push_pc    (pc),
        .push_instr (imem_data),
        .count      (count),
        .head_valid (out_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic [31:0] mem [2048];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic head(input string tag, input logic [31:0] ins, input logic [31:0] pcv);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " instr"}, out_instr, ins);
        chk({tag, " pc"}, out_pc, pcv);
    endtask

    task automatic empty(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " instr"}, out_instr, 32'd0);
        chk({tag, " pc"}, out_pc, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    logic [31:0] seq [6];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 3);

        // Reset state
        out_ready = 1'b1;
        @(negedge clk);
        empty("rst");
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst addr", 32'(imem_addr), 32'd0);
        reset = 1'b0;

        // Streaming at full rate
        for (int i = 0; i < 4; i++) begin
            step();
            head($sformatf("stream%0d", i), 32'(i + 3), 32'(4 * i));
        end

        // Back-pressure: buffer saturates, then drains in order
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("stall count", 32'(dut.count), 32'd2);
        chk("stall addr", 32'(imem_addr), 32'd2);
        head("stall head", 32'd3, 32'd0);
        out_ready = 1'b1;
        step();
        head("drain1", 32'd4, 32'd4);
        step();
        head("drain2", 32'd5, 32'd8);
        step();
        head("drain3", 32'd6, 32'd12);

        // Redirect while full
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) step();
        redirect(32'h50);
        empty("redir bubble");
        step();
        head("redir target", 32'd20, 32'h50);

        // Misaligned redirect target is word-aligned
        out_ready = 1'b1;
        redirect(32'h53);
        chk("misal addr", 32'(imem_addr), 32'd20);
        step();
        head("misal target", 32'd20, 32'h50);
        step();
        head("misal next", 32'd21, 32'h54);

        // ebreak halts fetching; redirect restarts
        mem[5] = EBRK;
        seq = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd4, EBRK};
        redirect(32'h0);
        empty("ebk bubble");
        for (int i = 0; i < 6; i++) begin
            step();
            head($sformatf("ebk%0d", i), seq[i], 32'(4 * i));
        end
        chk("ebk halted", 32'(halted), 32'd1);
        step();
        empty("halt drained");
        chk("halt addr", 32'(imem_addr), 32'd6);
        step();
        empty("halt idle");
        chk("halt still", 32'(halted), 32'd1);
        redirect(32'h0);
        chk("unhalt", 32'(halted), 32'd0);
        step();
        head("restart", 32'd3, 32'd0);
        mem[5] = 32'd5;

        // Asynchronous reset mid-cycle while streaming
        step();
        step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        empty("async rst");
        chk("async halted", 32'(halted), 32'd0);
        chk("async addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        head("post rst", 32'd3, 32'd0);
        step();
        head("post rst2", 32'd4, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Reader side of the instruction-memory interface: owns the program counter, drives the word address into the combinational instruction memory, and captures each returned word with its PC into a 2-entry buffer. Presents instructions to the decode stage through a valid/ready handshake. Supports branch/jump redirect with buffer flush, and halts fetching after an `ebreak`. Sits between `instructions_memory` and the decode stage in the fetch path.

## Interface
- `XLEN`, 32: instruction and PC width.
- `ADDR_W`, 11: instruction-memory word-address width (2048 words).
- `RESET_PC`, 32'h0000_0000: byte PC loaded at reset.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  ADDR_W  word address to instruction memory, `pc[ADDR_W+1:2]`.
- `imem_data`  in  XLEN  instruction word, combinational from `imem_addr`.
- `redirect_valid`  in  1  redirect request from execute.
- `redirect_pc`  in  XLEN  byte target of redirect.
- `out_valid`  out  1  buffer head holds an instruction.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_instr`  out  XLEN  head instruction; 0 when empty.
- `out_pc`  out  XLEN  byte PC of head; 0 when empty.
- `halted`  out  1  high in HALTED state.

## Operation
- State machine `RUN` / `HALTED`. Reset → `RUN`.
- `pop` = `out_valid & out_ready`.
- `fetch` = state `RUN` & !`redirect_valid` & (count < 2 | `pop`).
- On `fetch`: enqueue {`pc`, `imem_data`}, `pc` ← `pc` + 4 (mod 2^XLEN).
- Enqueued word == 32'h0010_0073 (`ebreak`): the word itself is enqueued, state → `HALTED`, `pc` stops at ebreak+4. HALTED issues no fetches. Buffer continues to drain.
- `redirect_valid` (any state): buffer flushed (count ← 0), `pc` ← `redirect_pc` with bits [1:0] cleared, state → `RUN`. The same-cycle fetch and pop are discarded. Redirect overrides all other events.
- PC bits above `ADDR_W+1` do not drive `imem_addr`. Addresses alias modulo 8 KiB. The full 32-bit `pc` is still reported on `out_pc`.
- Buffer order is strict FIFO. Simultaneous enqueue and pop at count 2 is legal and keeps count at 2. At count 0 a pop cannot occur.

## Timing
- Reset values: `pc` = `RESET_PC`, count = 0, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `halted` = 0, `imem_addr` = `RESET_PC[ADDR_W+1:2]`.
- Latency: a word addressed in cycle N appears on `out_*` in cycle N+1 (registered buffer).
- Throughput: one instruction per cycle while `out_ready` is held high.
- First instruction is valid in the first cycle after reset deasserts.
- Redirect in cycle N: `out_valid` = 0 in N+1. Target instruction is valid in N+2.
- `halted` asserts in the cycle after the `ebreak` is enqueued.
- Reset asserted mid-stream clears the buffer and state immediately, asynchronously.

## Structure
- Package `fetch_pkg`:
  - `XLEN` and `ADDR_W` defaults.
  - `EBREAK` = 32'h0010_0073.
  - `PC_STEP` = 4.
  - `fetch_state_t` enum {`RUN`, `HALTED`}.
- Sub-module `fetch_buffer`: 2-entry FIFO of {pc, instr} with push, pop, flush, count, and head outputs. Zero output when empty. Reset clears it.
- Top holds the PC register, FSM, and fetch/redirect control.

## Test plan
- Memory words 0–3 = 3, 4, 5, 6; `out_ready` = 1 → after reset, `out_instr` = 3, 4, 5, 6 on consecutive cycles with `out_pc` = 0, 4, 8, 12.
- `out_ready` = 0 for 5 cycles → count saturates at 2, `pc` = 8, `imem_addr` = 2. On release, 3, 4, 5 delivered in order with no gaps or duplicates.
- Redirect to 32'h50 while the buffer is full → next cycle `out_valid` = 0, following cycle `out_instr` = Memory[20] = 20 with `out_pc` = 32'h50.
- Redirect to 32'h53 (misaligned) → fetch starts at `out_pc` = 32'h50.
- Word 5 = `ebreak` → words 0–5 delivered, `halted` = 1, no further enqueues. A subsequent redirect to 0 clears `halted` and restarts at word 0.
- Assert `reset` mid-cycle during streaming → outputs go to reset values immediately, without waiting for `clk`. After release, the stream restarts at `RESET_PC`.
